// File: rtl/load_store_ctrl.sv
// Load/store controller: turns single CPU byte/half/word accesses into
// word-wide data-memory commands. Sub-word stores are done as
// read-modify-write, loads are lane-extracted and sign/zero-extended.
//
// Handshake: a request is accepted on a rising edge where req_valid_i and
// req_ready_o are both 1; ready is only offered in IDLE outside reset, and
// requests presented while busy are ignored. The response is a single-cycle
// resp_valid_o pulse with no backpressure; resp_rdata_o/resp_err_o are zero
// whenever resp_valid_o is low.
module load_store_ctrl (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   output logic [2:0]  mem_signal_o,
   input  logic [31:0] mem_data_i,
   output logic [2:0]  state_dbg_o
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD      = 3'd1,
      S_RD_WAIT = 3'd2,
      S_WR      = 3'd3,
      S_RESP    = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic        we_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [1:0]  lane_q;
   logic [31:0] wdata_q;
   logic        err_q;
   logic [31:0] rdata_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_data_q;

   logic        accept;
   logic        misaligned;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_val;
   logic [31:0] merge_val;

   assign accept = req_valid_i && req_ready_o;

   // Reserved size, or an address not aligned to the access size.
   always_comb begin
      misaligned = 1'b0;
      case (req_size_i)
         2'b01:   misaligned = req_addr_i[0];
         2'b10:   misaligned = (req_addr_i[1:0] != 2'b00);
         2'b11:   misaligned = 1'b1;
         default: misaligned = 1'b0;
      endcase
   end

   // Next-state logic; sub-word stores detour through a read first.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (misaligned)                state_d = S_RESP;
               else if (!req_we_i)            state_d = S_RD;
               else if (req_size_i == 2'b10)  state_d = S_WR;
               else                           state_d = S_RD;
            end
         end
         S_RD:      state_d = S_RD_WAIT;
         S_RD_WAIT: state_d = we_q ? S_WR : S_RESP;
         S_WR:      state_d = S_RESP;
         S_RESP:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Lane extraction for loads and lane merge for read-modify-write stores.
   always_comb begin
      byte_sel  = 8'h00;
      case (lane_q)
         2'd0:    byte_sel = mem_data_i[7:0];
         2'd1:    byte_sel = mem_data_i[15:8];
         2'd2:    byte_sel = mem_data_i[23:16];
         default: byte_sel = mem_data_i[31:24];
      endcase
      half_sel = lane_q[1] ? mem_data_i[31:16] : mem_data_i[15:0];
      case (size_q)
         2'b00:   load_val = {{24{byte_sel[7] & ~uns_q}}, byte_sel};
         2'b01:   load_val = {{16{half_sel[15] & ~uns_q}}, half_sel};
         default: load_val = mem_data_i;
      endcase
      merge_val = mem_data_i;
      if (size_q == 2'b00) begin
         case (lane_q)
            2'd0:    merge_val[7:0]   = wdata_q[7:0];
            2'd1:    merge_val[15:8]  = wdata_q[7:0];
            2'd2:    merge_val[23:16] = wdata_q[7:0];
            default: merge_val[31:24] = wdata_q[7:0];
         endcase
      end else if (lane_q[1]) begin
         merge_val[31:16] = wdata_q[15:0];
      end else begin
         merge_val[15:0] = wdata_q[15:0];
      end
   end

   // State and request registers; memory address/data only change when a
   // command is about to be issued so they stay stable otherwise.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         we_q       <= 1'b0;
         size_q     <= 2'b00;
         uns_q      <= 1'b0;
         lane_q     <= 2'b00;
         wdata_q    <= 32'h0;
         err_q      <= 1'b0;
         rdata_q    <= 32'h0;
         mem_addr_q <= 32'h0;
         mem_data_q <= 32'h0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q    <= req_we_i;
            size_q  <= req_size_i;
            uns_q   <= req_unsigned_i;
            lane_q  <= req_addr_i[1:0];
            wdata_q <= req_wdata_i;
            err_q   <= misaligned;
            rdata_q <= 32'h0;
            if (!misaligned) begin
               mem_addr_q <= {req_addr_i[31:2], 2'b00};
               if (req_we_i && (req_size_i == 2'b10)) mem_data_q <= req_wdata_i;
            end
         end
         if (state_q == S_RD_WAIT) begin
            if (we_q) mem_data_q <= merge_val;
            else      rdata_q    <= load_val;
         end
      end
   end

   assign req_ready_o  = (state_q == S_IDLE) && !rst_i;
   assign resp_valid_o = (state_q == S_RESP);
   assign resp_rdata_o = resp_valid_o ? rdata_q : 32'h0;
   assign resp_err_o   = resp_valid_o ? err_q : 1'b0;
   assign mem_addr_o   = mem_addr_q;
   assign mem_data_o   = mem_data_q;
   assign mem_signal_o = rst_i              ? 3'b000 :
                         (state_q == S_RD)  ? 3'b010 :
                         (state_q == S_WR)  ? 3'b001 : 3'b000;
   assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_load_store_ctrl.sv
// Bench for load_store_ctrl: a word-addressed memory model answers the
// DUT's commands; a driver issues requests and pushes the expected response
// and expected per-cycle memory commands; a negedge monitor checks them.
module tb_load_store_ctrl;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
   logic [1:0]  req_size_i;
   logic [31:0] req_addr_i, req_wdata_i;
   logic        resp_valid_o, resp_err_o;
   logic [31:0] resp_rdata_o, mem_addr_o, mem_data_o, mem_data_i;
   logic [2:0]  mem_signal_o, state_dbg_o;

   load_store_ctrl dut (
      .clk_i(clk), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_we_i(req_we_i), .req_size_i(req_size_i),
      .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
      .req_wdata_i(req_wdata_i),
      .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
      .resp_err_o(resp_err_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .mem_signal_o(mem_signal_o), .mem_data_i(mem_data_i),
      .state_dbg_o(state_dbg_o)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- memory environment ----------------
   logic [31:0] mem [int];
   logic [31:0] mem_rd_q = 32'h0;
   assign mem_data_i = mem_rd_q;

   function automatic logic [31:0] env_rd(int k);
      return mem.exists(k) ? mem[k] : 32'h0;
   endfunction

   always @(posedge clk) begin
      if (mem_signal_o[1]) mem_rd_q <= env_rd(int'(mem_addr_o[31:2]));
      if (mem_signal_o[0]) mem[int'(mem_addr_o[31:2])] = mem_data_o;
   end

   // ---------------- reference model / scoreboard ----------------
   logic [31:0] ref_mem [int];
   logic [32:0] exp_q[$];
   int          due_q[$];
   logic [2:0]  exp_sig [int];
   logic [31:0] exp_addr [int];
   logic [31:0] exp_wd [int];
   int          busy_start = 1, busy_end = 0;
   int          total = 0, bad = 0;
   logic [31:0] last_rdata = 32'h0;

   function automatic logic [31:0] ref_rd(int k);
      return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
   endfunction

   function automatic logic [31:0] load_ref(logic [31:0] word, logic [1:0] size,
                                            logic uns, logic [1:0] lo);
      logic [31:0] v;
      if (size == 2'b10) return word;
      if (size == 2'b00) begin
         v = (word >> (8 * lo)) & 32'hFF;
         if (!uns && v[7]) v = v | 32'hFFFFFF00;
      end else begin
         v = (word >> (16 * lo[1])) & 32'hFFFF;
         if (!uns && v[15]) v = v | 32'hFFFF0000;
      end
      return v;
   endfunction

   function automatic logic [31:0] merge_ref(logic [31:0] word, logic [1:0] size,
                                             logic [1:0] lo, logic [31:0] wd);
      int sh;
      logic [31:0] mask;
      sh   = (size == 2'b00) ? 8 * lo : 16 * lo[1];
      mask = ((size == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
      return (word & ~mask) | ((wd << sh) & mask);
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic fail_now(string name);
      total++;
      bad++;
      $display("FAIL %s at cycle %0d", name, cyc);
   endtask

   task automatic preload(logic [31:0] addr, logic [31:0] v);
      mem[int'(addr[31:2])]     = v;
      ref_mem[int'(addr[31:2])] = v;
   endtask

   // ---------------- driver tasks (entered and left just after a posedge) --
   task automatic issue(logic we, logic [1:0] size, logic uns,
                        logic [31:0] addr, logic [31:0] wdata);
      int a, lat, k, waited;
      logic err;
      logic [31:0] word, res;
      #1;
      req_valid_i = 1'b1; req_we_i = we; req_size_i = size;
      req_unsigned_i = uns; req_addr_i = addr; req_wdata_i = wdata;
      waited = 0;
      while (!req_ready_o && waited < 20) begin
         @(posedge clk); #1; waited++;
      end
      if (!req_ready_o) begin
         fail_now("ready_timeout");
         return;
      end
      a    = cyc + 1;
      k    = int'(addr[31:2]);
      word = ref_rd(k);
      err  = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
             (size == 2'b10 && addr[1:0] != 2'b00);
      res  = 32'h0;
      if (err) begin
         lat = 1;
      end else if (!we) begin
         lat = 3;
         res = load_ref(word, size, uns, addr[1:0]);
         exp_sig[a] = 3'b010; exp_addr[a] = {addr[31:2], 2'b00};
      end else if (size == 2'b10) begin
         lat = 2;
         exp_sig[a] = 3'b001; exp_addr[a] = {addr[31:2], 2'b00}; exp_wd[a] = wdata;
         ref_mem[k] = wdata;
      end else begin
         lat = 4;
         exp_sig[a] = 3'b010; exp_addr[a] = {addr[31:2], 2'b00};
         exp_sig[a+2] = 3'b001; exp_addr[a+2] = {addr[31:2], 2'b00};
         exp_wd[a+2] = merge_ref(word, size, addr[1:0], wdata);
         ref_mem[k] = exp_wd[a+2];
      end
      exp_q.push_back({err, res});
      due_q.push_back(a + lat - 1);
      busy_start = a;
      busy_end   = a + lat - 1;
      @(posedge clk);
   endtask

   task automatic idle(int n);
      #1;
      req_valid_i = 1'b0;
      repeat (n) @(posedge clk);
   endtask

   task automatic drain();
      int w;
      #1;
      req_valid_i = 1'b0;
      w = 0;
      while (exp_q.size() > 0 && w < 50) begin
         @(posedge clk); w++;
      end
      if (exp_q.size() > 0) begin
         fail_now("drain_timeout");
         exp_q.delete();
         due_q.delete();
      end
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_resp_valid"}, resp_valid_o, 0);
      check({tag, "_resp_rdata"}, resp_rdata_o, 0);
      check({tag, "_resp_err"},   resp_err_o, 0);
      check({tag, "_mem_signal"}, mem_signal_o, 0);
      check({tag, "_mem_addr"},   mem_addr_o, 0);
      check({tag, "_mem_data"},   mem_data_o, 0);
      check({tag, "_ready"},      req_ready_o, 0);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [2:0]  es;
      logic [32:0] e;
      int          due;
      if (rst_i) begin
         check("mem_signal_in_reset", mem_signal_o, 0);
         check("ready_in_reset", req_ready_o, 0);
      end else begin
         es = exp_sig.exists(cyc) ? exp_sig[cyc] : 3'b000;
         check("mem_signal", mem_signal_o, es);
         if (es != 3'b000) check("mem_addr", mem_addr_o, exp_addr[cyc]);
         if (es == 3'b001) check("mem_wdata", mem_data_o, exp_wd[cyc]);
         check("req_ready", req_ready_o, !(cyc >= busy_start && cyc <= busy_end));
      end
      if (resp_valid_o) begin
         if (exp_q.size() == 0) begin
            fail_now("unexpected_resp");
         end else begin
            e   = exp_q.pop_front();
            due = due_q.pop_front();
            check("resp_rdata", resp_rdata_o, e[31:0]);
            check("resp_err", resp_err_o, e[32]);
            check("resp_cycle", cyc, due);
            last_rdata = resp_rdata_o;
         end
      end else begin
         check("idle_rdata_zero", resp_rdata_o, 0);
         check("idle_err_zero", resp_err_o, 0);
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #400000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int a;
      logic [31:0] saved;
      rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00;
      req_unsigned_i = 1'b0; req_addr_i = 32'h0; req_wdata_i = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");
      rst_i = 1'b0;
      @(posedge clk);

      // byte loads, signed and unsigned
      preload(32'h10, 32'h8899AABB);
      issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
      drain();
      check("lb_value", last_rdata, 32'hFFFFFFAA);
      issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
      drain();
      check("lbu_value", last_rdata, 32'h000000AA);

      // half store read-modify-write
      issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234);
      drain();
      check("sh_mem_word", env_rd(4), 32'h1234AABB);

      // word store then word load back-to-back
      issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF);
      issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
      drain();
      check("sw_lw_value", last_rdata, 32'hDEADBEEF);

      // misaligned and reserved-size requests
      issue(1'b0, 2'b10, 1'b0, 32'h22, 32'h0);
      issue(1'b0, 2'b01, 1'b0, 32'h23, 32'h0);
      issue(1'b1, 2'b11, 1'b0, 32'h24, 32'h55);
      drain();

      // reset during the write phase of a byte store
      preload(32'h30, 32'h11223344);
      saved = ref_rd(12);
      issue(1'b1, 2'b00, 1'b0, 32'h30, 32'h000000AB);
      a = cyc;
      while (cyc < a + 2) @(posedge clk);
      #1;
      rst_i = 1'b1;
      req_valid_i = 1'b0;
      exp_q.delete(); due_q.delete();
      exp_sig.delete(); exp_addr.delete(); exp_wd.delete();
      busy_start = 1; busy_end = 0;
      ref_mem[12] = saved;
      @(posedge clk);
      #1;
      check_reset_outputs("abort");
      check("abort_mem_kept", env_rd(12), 32'h11223344);
      rst_i = 1'b0;
      @(posedge clk);

      // alternating word stores/loads with valid held high
      for (int i = 0; i < 12; i++)
         issue(i[0], 2'b10, 1'b0, {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom);
      drain();

      // randomized mix
      for (int i = 0; i < 200; i++) begin
         int s;
         logic [1:0] sz;
         s  = $urandom_range(0, 9);
         sz = (s < 3) ? 2'b00 : (s < 6) ? 2'b01 : (s < 9) ? 2'b10 : 2'b11;
         issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
               32'($urandom_range(0, 63)), $urandom);
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
      drain();
      repeat (3) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/load_store_ctrl.md
LOAD_STORE_CTRL -- requirements
Module: load_store_ctrl

Interface
REQ-001: clk_i  input  1  single clock; all state updates on rising edge.
REQ-002: rst_i  input  1  reset, synchronous, active-high.
REQ-003: req_valid_i  input  1  CPU access request present.
REQ-004: req_ready_o  output  1  block can accept a request this cycle.
REQ-005: req_we_i  input  1  1 = store, 0 = load.
REQ-006: req_size_i  input  2  00 byte, 01 half, 10 word; 11 reserved, treated as an error.
REQ-007: req_unsigned_i  input  1  load zero-extends when 1, sign-extends when 0.
REQ-008: req_addr_i  input  32  byte address.
REQ-009: req_wdata_i  input  32  store data, right-justified.
REQ-010: resp_valid_o  output  1  one-cycle completion pulse; no backpressure.
REQ-011: resp_rdata_o  output  32  load result; 0 for stores and errors.
REQ-012: resp_err_o  output  1  misaligned or reserved-size request; valid with resp_valid_o.
REQ-013: mem_addr_o  output  32  word-aligned address {req_addr[31:2],2'b00} to data memory.
REQ-014: mem_data_o  output  32  little-endian write word to data memory.
REQ-015: mem_signal_o  output  3  bit0 write, bit1 read, bit2 always 0.
REQ-016: mem_data_i  input  32  read word from data memory; valid in the cycle after a read command.

Function
REQ-017: States: IDLE, RD, RD_WAIT, WR, RESP. req_ready_o = 1 only in IDLE with rst_i low.
REQ-018: Request accepted on a rising edge where req_valid_i and req_ready_o are both 1; addr, size, we, unsigned and wdata are registered at that edge.
REQ-019: Misaligned accepts go IDLE->RESP with resp_err_o=1 and make no memory command: half with addr[0]=1, word with addr[1:0]!=0, or size 11.
REQ-020: Load path IDLE->RD->RD_WAIT->RESP; RD drives mem_signal_o=010; mem_data_i is captured at the end of RD_WAIT; resp_valid_o is high 3 cycles after acceptance.
REQ-021: Word store IDLE->WR->RESP; WR drives mem_signal_o=001 with mem_data_o=wdata; resp_valid_o is high 2 cycles after acceptance.
REQ-022: Byte/half store is read-modify-write IDLE->RD->RD_WAIT->WR->RESP; only the addressed lane(s) of the captured word are replaced; resp_valid_o is high 4 cycles after acceptance.
REQ-023: Lane select: byte lane = addr[1:0] (lane 0 = bits 7:0); half lane = addr[1] (0 -> bits 15:0, 1 -> bits 31:16).
REQ-024: Load result = selected lane shifted to bit 0, then zero- or sign-extended to 32 bits per req_unsigned_i; word loads return the word unchanged.
REQ-025: mem_signal_o = 000 in IDLE, RD_WAIT and RESP, and in any cycle rst_i is high; read and write bits are never both 1.
REQ-026: mem_addr_o and mem_data_o hold their values outside RD/WR; their content there is don't-care but they are stable.
REQ-027: RESP lasts exactly one cycle, then returns to IDLE; a new request can be accepted the cycle after RESP (back-to-back issue interval = latency + 1).
REQ-028: req_valid_i during non-IDLE states is ignored, not queued.
REQ-029: resp_rdata_o and resp_err_o are meaningful only while resp_valid_o = 1 and are 0 otherwise.

Reset
REQ-030: With rst_i high at a rising edge, the state becomes IDLE. After that edge: resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, mem_signal_o=000, mem_addr_o=0, mem_data_o=0; req_ready_o becomes 1 after rst_i is released.
REQ-031: Reset mid-operation aborts the access with no response; a store in WR is not committed because REQ-025 gates the write bit.

Verification
REQ-032: Preload word 0x8899AABB at addr 0x10; lb addr 0x11, signed -> resp_rdata 0xFFFFFFAA, 3 cycles after accept; lbu -> 0x000000AA.
REQ-033: Preload 0x8899AABB at 0x10; sh wdata 0x00001234 at addr 0x12 -> memory word 0x1234AABB; read at T+1, write at T+3, resp at T+4, err=0.
REQ-034: sw 0xDEADBEEF at 0x20, then lw 0x20 -> 0xDEADBEEF; second request accepted the cycle after the first RESP.
REQ-035: lw at 0x22 and lh at 0x23 -> each gives resp_err=1 one cycle after accept; mem_signal stays 000 throughout.
REQ-036: sb at 0x30 with rst_i asserted during WR -> no write to memory (prior contents kept), no resp_valid, req_ready=1 the cycle after reset releases.
REQ-037: req_valid held high continuously with alternating loads/stores -> exactly one response per accepted request, and req_ready low in every non-IDLE cycle.
